// File: rtl/usr_shift_reg_pkg.sv
// Shared mode encoding for the universal shift register and its bit cells.
package usr_shift_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD = 2'b00;
  localparam mode_t MODE_SHL  = 2'b01;
  localparam mode_t MODE_SHR  = 2'b10;
  localparam mode_t MODE_LOAD = 2'b11;

  function automatic logic is_shift(input mode_t m);
    return (m == MODE_SHL) || (m == MODE_SHR);
  endfunction

endpackage

// File: rtl/usr_shift_reg_cell.sv
// One bit of the universal shift register: 4:1 next-value mux, enable,
// asynchronous active-high reset to a per-bit value.
module usr_cell
  import usr_shift_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  en,
  input  mode_t mode,
  input  logic  left_i,   // lower-index neighbour, moves in on shift left
  input  logic  right_i,  // higher-index neighbour, moves in on shift right
  input  logic  load_i,
  output logic  q_o
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (en) begin
      case (mode)
        MODE_SHL:  q_d = left_i;
        MODE_SHR:  q_d = right_i;
        MODE_LOAD: q_d = load_i;
        default:   q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/usr_shift_reg.sv
// Universal shift register: WIDTH bit cells plus a saturating shift counter
// that emits a one-cycle frame_done pulse on the WIDTH-th shift after load/reset.
module usr_shift_reg
  import usr_shift_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  mode_t            mode,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  input  logic [WIDTH-1:0] pdin,
  output logic [WIDTH-1:0] q,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic [CNT_W-1:0] cnt,
  output logic             frame_done
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] q_vec;
  logic [WIDTH-1:0] left_nb;
  logic [WIDTH-1:0] right_nb;

  // End cells see the serial inputs in place of a missing neighbour.
  assign left_nb  = {q_vec[WIDTH-2:0], sin_lsb};
  assign right_nb = {sin_msb, q_vec[WIDTH-1:1]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    usr_cell #(
      .RST_VAL(RESET_VAL[i])
    ) u_cell (
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .mode   (mode),
      .left_i (left_nb[i]),
      .right_i(right_nb[i]),
      .load_i (pdin[i]),
      .q_o    (q_vec[i])
    );
  end

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             frame_q;
  logic             frame_d;

  // Saturation at CNT_FULL is what keeps frame_done from re-firing.
  always_comb begin
    cnt_d   = cnt_q;
    frame_d = 1'b0;
    if (en) begin
      if (mode == MODE_LOAD) begin
        cnt_d = '0;
      end else if (is_shift(mode) && (cnt_q != CNT_FULL)) begin
        cnt_d   = cnt_q + CNT_W'(1);
        frame_d = (cnt_q == CNT_LAST);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
    end
  end

  assign q          = q_vec;
  assign sout_msb   = q_vec[WIDTH-1];
  assign sout_lsb   = q_vec[0];
  assign cnt        = cnt_q;
  assign frame_done = frame_q;

endmodule

// File: tb/tb_usr_shift_reg.sv
// Self-checking bench for usr_shift_reg (WIDTH=4) against an arithmetic reference model.
module tb_usr_shift_reg;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         en;
  logic [1:0]   mode;
  logic         sin_lsb;
  logic         sin_msb;
  logic [W-1:0] pdin;
  logic [W-1:0] q;
  logic         sout_msb;
  logic         sout_lsb;
  logic [2:0]   cnt;
  logic         frame_done;

  usr_shift_reg #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .mode      (mode),
    .sin_lsb   (sin_lsb),
    .sin_msb   (sin_msb),
    .pdin      (pdin),
    .q         (q),
    .sout_msb  (sout_msb),
    .sout_lsb  (sout_lsb),
    .cnt       (cnt),
    .frame_done(frame_done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // ---------------- reference model + scoreboard ----------------
  int         n_checks = 0;
  int         n_errors = 0;
  logic [W-1:0] m_q;
  logic [2:0]   m_cnt;
  logic         m_fd;
  logic [W-1:0] exp_q[$];   // expected serial-out bits, oldest first

  task automatic model_reset();
    m_q   = '0;
    m_cnt = '0;
    m_fd  = 1'b0;
  endtask

  // Apply one operation at the negedge, advance model and DUT across the
  // posedge, and return 1 ns after the edge ready for sampling.
  task automatic step(input logic e, input logic [1:0] md, input logic sl,
                      input logic sm, input logic [W-1:0] pd);
    @(negedge clk);
    en = e; mode = md; sin_lsb = sl; sin_msb = sm; pdin = pd;
    @(posedge clk);
    m_fd = 1'b0;
    if (e) begin
      if (md == 2'b11) begin
        m_q   = pd;
        m_cnt = '0;
      end else if (md == 2'b01 || md == 2'b10) begin
        if (md == 2'b01) m_q = (m_q << 1) | {3'b000, sl};
        else             m_q = (m_q >> 1) | {sm, 3'b000};
        if (m_cnt < 3'(W)) begin
          m_fd  = (m_cnt == 3'(W - 1));
          m_cnt = m_cnt + 3'd1;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0; mode = 2'b00;
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; en = 1'b0; mode = 2'b00; sin_lsb = 1'b0; sin_msb = 1'b0; pdin = '0;
    model_reset();
    #1;
    n_checks++;
    if (q !== 4'b0000 || cnt !== 3'd0 || frame_done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_init: got q=%b cnt=%0d fd=%b want q=0000 cnt=0 fd=0", q, cnt, frame_done);
    end
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 2'b11, 1'b0, 1'b0, 4'b1011);
    n_checks++;
    if (q !== 4'b1011) begin
      n_errors++;
      $display("FAIL reset_preload: got q=%b want 1011", q);
    end
    // Assert reset between edges; outputs must clear without a clock edge.
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (q !== 4'b0000 || cnt !== 3'd0 || frame_done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_async: got q=%b cnt=%0d fd=%b want q=0000 cnt=0 fd=0", q, cnt, frame_done);
    end
    en = 1'b1; mode = 2'b11; pdin = 4'b1111;
    @(posedge clk);
    #1;
    n_checks++;
    if (q !== 4'b0000 || cnt !== 3'd0) begin
      n_errors++;
      $display("FAIL reset_hold: got q=%b cnt=%0d want q=0000 cnt=0", q, cnt);
    end
    @(negedge clk);
    en = 1'b0; mode = 2'b00;
    reset = 1'b0;
  endtask

  task automatic test_shift_left();
    logic [3:0] bits;
    bits = 4'b1011;   // driven msb first: 1,0,1,1
    do_reset();
    for (int i = 0; i < W; i++) begin
      step(1'b1, 2'b01, bits[W-1-i], 1'($urandom_range(0, 1)), 4'($urandom));
      n_checks++;
      if (q !== m_q || cnt !== m_cnt || frame_done !== m_fd) begin
        n_errors++;
        $display("FAIL shl_step%0d: got q=%b cnt=%0d fd=%b want q=%b cnt=%0d fd=%b",
                 i, q, cnt, frame_done, m_q, m_cnt, m_fd);
      end
    end
    n_checks++;
    if (q !== 4'b1011 || cnt !== 3'd4 || frame_done !== 1'b1) begin
      n_errors++;
      $display("FAIL shl_final: got q=%b cnt=%0d fd=%b want q=1011 cnt=4 fd=1", q, cnt, frame_done);
    end
    step(1'b1, 2'b00, 1'b0, 1'b0, '0);
    n_checks++;
    if (frame_done !== 1'b0) begin
      n_errors++;
      $display("FAIL shl_pulse_end: got fd=%b want 0", frame_done);
    end
  endtask

  task automatic test_load_shr();
    logic [W-1:0] pd;
    int           pulses;
    pd = 4'b1101;
    pulses = 0;
    step(1'b1, 2'b11, 1'b0, 1'b0, pd);
    n_checks++;
    if (q !== pd || cnt !== 3'd0 || frame_done !== 1'b0) begin
      n_errors++;
      $display("FAIL shr_load: got q=%b cnt=%0d fd=%b want q=%b cnt=0 fd=0", q, cnt, frame_done, pd);
    end
    for (int i = 0; i < W; i++) exp_q.push_back(W'((pd >> i) & 4'b0001));
    for (int i = 0; i < W; i++) begin
      logic [W-1:0] e_bit;
      e_bit = exp_q.pop_front();
      n_checks++;
      if ({3'b000, sout_lsb} !== e_bit || sout_msb !== m_q[W-1]) begin
        n_errors++;
        $display("FAIL shr_sout%0d: got lsb=%b msb=%b want lsb=%b msb=%b",
                 i, sout_lsb, sout_msb, e_bit[0], m_q[W-1]);
      end
      step(1'b1, 2'b10, 1'($urandom_range(0, 1)), 1'b0, '0);
      if (frame_done === 1'b1) pulses++;
    end
    n_checks++;
    if (q !== 4'b0000 || cnt !== 3'd4 || pulses != 1) begin
      n_errors++;
      $display("FAIL shr_final: got q=%b cnt=%0d pulses=%0d want q=0000 cnt=4 pulses=1", q, cnt, pulses);
    end
  endtask

  task automatic test_saturation();
    int pulses;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'($urandom_range(1, 2)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), '0);
      n_checks++;
      if (cnt !== 3'd4 || frame_done !== 1'b0 || q !== m_q) begin
        n_errors++;
        $display("FAIL sat_step%0d: got q=%b cnt=%0d fd=%b want q=%b cnt=4 fd=0", i, q, cnt, frame_done, m_q);
      end
    end
    step(1'b1, 2'b11, 1'b0, 1'b0, 4'b0110);
    n_checks++;
    if (cnt !== 3'd0 || q !== 4'b0110) begin
      n_errors++;
      $display("FAIL sat_reload: got q=%b cnt=%0d want q=0110 cnt=0", q, cnt);
    end
    pulses = 0;
    for (int i = 0; i < W; i++) begin
      step(1'b1, 2'($urandom_range(1, 2)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), '0);
      if (frame_done === 1'b1) pulses++;
      n_checks++;
      if (frame_done !== m_fd || cnt !== m_cnt) begin
        n_errors++;
        $display("FAIL rearm_step%0d: got cnt=%0d fd=%b want cnt=%0d fd=%b", i, cnt, frame_done, m_cnt, m_fd);
      end
    end
    n_checks++;
    if (pulses != 1 || frame_done !== 1'b1) begin
      n_errors++;
      $display("FAIL rearm_pulse: got pulses=%0d fd=%b want pulses=1 fd=1", pulses, frame_done);
    end
  endtask

  task automatic test_enable_hold();
    logic [W-1:0] q0;
    step(1'b1, 2'b11, 1'b0, 1'b0, 4'b1001);
    step(1'b1, 2'b01, 1'b1, 1'b0, '0);
    q0 = m_q;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'b01, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom));
      n_checks++;
      if (q !== q0 || cnt !== 3'd1 || frame_done !== 1'b0) begin
        n_errors++;
        $display("FAIL en_low%0d: got q=%b cnt=%0d fd=%b want q=%b cnt=1 fd=0", i, q, cnt, frame_done, q0);
      end
    end
    step(1'b1, 2'b00, 1'b1, 1'b1, 4'($urandom));
    n_checks++;
    if (q !== q0 || cnt !== 3'd1 || frame_done !== 1'b0) begin
      n_errors++;
      $display("FAIL hold_mode: got q=%b cnt=%0d fd=%b want q=%b cnt=1 fd=0", q, cnt, frame_done, q0);
    end
  endtask

  task automatic test_mixed();
    step(1'b1, 2'b11, 1'b0, 1'b0, 4'b1000);
    step(1'b1, 2'b01, 1'b1, 1'b0, '0);
    n_checks++;
    if (q !== 4'b0001 || cnt !== 3'd1) begin
      n_errors++;
      $display("FAIL mixed_shl: got q=%b cnt=%0d want q=0001 cnt=1", q, cnt);
    end
    step(1'b1, 2'b10, 1'b0, 1'b1, '0);
    n_checks++;
    if (q !== 4'b1000 || cnt !== 3'd2 || frame_done !== 1'b0) begin
      n_errors++;
      $display("FAIL mixed_shr: got q=%b cnt=%0d fd=%b want q=1000 cnt=2 fd=0", q, cnt, frame_done);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 4'($urandom));
      n_checks++;
      if (q !== m_q || cnt !== m_cnt || frame_done !== m_fd ||
          sout_msb !== m_q[W-1] || sout_lsb !== m_q[0]) begin
        n_errors++;
        $display("FAIL rand%0d: got q=%b cnt=%0d fd=%b so=%b%b want q=%b cnt=%0d fd=%b",
                 i, q, cnt, frame_done, sout_msb, sout_lsb, m_q, m_cnt, m_fd);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_shift_left();
    test_load_shr();
    test_saturation();
    test_enable_hold();
    test_mixed();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
